uart_sram_tx_interface: RTL and testbench

Reads a contiguous block of 16-bit words from SRAM and serialises each word over UART TX (8N1, high byte first). It is the transmit counterpart of the UART-receive-to-SRAM path and lets a captured image be dumped back to the PC. It sits beside the UART receive unit on the SRAM arbitration mux and is granted SRAM while its Busy output is high. It never writes SRAM.

---
 rtl/uart_sram_tx_interface_pkg.sv | 30 +++
 rtl/uart_sram_tx_interface_if.sv | 27 ++
 rtl/uart_sram_tx_interface_byte_tx.sv | 77 +++++++
 rtl/uart_sram_tx_interface.sv | 125 ++++++++++++
 tb/tb_uart_sram_tx_interface.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared types and constants for the SRAM-to-UART transmit path.
// Holds the transmit FSM states and the transfer bookkeeping struct.
package uart_sram_tx_interface_pkg;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int SRAM_ADDR_W              = 18;
  localparam int SRAM_DATA_W              = 16;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_ISSUE_READ,
    S_TX_WAIT_DATA,
    S_TX_SEND_HIGH,
    S_TX_WAIT_HIGH,
    S_TX_SEND_LOW,
    S_TX_WAIT_LOW,
    S_TX_DONE
  } tx_state_type;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_ADDR_W-1:0] remaining;
  } xfer_t;

  // The 18-bit address space wraps silently; a dump may straddle the top.
  function automatic logic [SRAM_ADDR_W-1:0] next_word_addr(input logic [SRAM_ADDR_W-1:0] addr);
    return addr + SRAM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_if.sv
// Control, SRAM read and UART line signals of the transmit unit.
// The slave modport is the transmit unit; master is whoever drives it.
interface uart_sram_tx_interface_if;
  import uart_sram_tx_interface_pkg::*;

  logic                   Start;
  logic                   Abort;
  logic [SRAM_ADDR_W-1:0] Start_address;
  logic [SRAM_ADDR_W-1:0] Word_count;
  logic [SRAM_ADDR_W-1:0] SRAM_address;
  logic [SRAM_DATA_W-1:0] SRAM_read_data;
  logic                   SRAM_we_n;
  logic                   UART_TX_O;
  logic                   Busy;
  logic                   Done;

  modport master (
    output Start, Abort, Start_address, Word_count, SRAM_read_data,
    input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

  modport slave (
    input  Start, Abort, Start_address, Word_count, SRAM_read_data,
    output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

endinterface

// File: rtl/uart_sram_tx_interface_byte_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// tx_busy covers the whole frame including the full stop bit.
module uart_byte_tx
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       UART_TX_O
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              line_q, line_d;

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    line_d  = line_q;
    if (!busy_q) begin
      if (tx_start) begin
        busy_d  = 1'b1;
        line_d  = 1'b0;
        shift_d = {1'b1, tx_data};
        bit_d   = '0;
        baud_d  = '0;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      if (bit_q == STOP_BIT) begin
        busy_d = 1'b0;
        line_d = 1'b1;
      end else begin
        // The stop '1' sits above the data and shifts down behind it.
        line_d  = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      line_q  <= line_d;
    end
  end

  assign tx_busy   = busy_q;
  assign UART_TX_O = line_q;

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends each over UART, high byte first.
// Read-only on SRAM; Busy tells the arbitration mux to grant this unit.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT      = UART_CLKS_PER_BIT_115200,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic                       CLOCK_50_I,
  input  logic                       resetn,
  uart_sram_tx_interface_if.slave    bus
);

  localparam int               LAT_W    = (SRAM_READ_LATENCY > 0) ? $clog2(SRAM_READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRAM_READ_LATENCY);

  tx_state_type           state_q, state_d;
  xfer_t                  xfer_q, xfer_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_W-1:0] word_q, word_d;
  logic [LAT_W-1:0]       lat_q, lat_d;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_line;

  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    sram_addr_d = sram_addr_q;
    word_d      = word_q;
    lat_d       = lat_q;
    tx_start    = 1'b0;
    tx_data     = word_q[7:0];

    unique case (state_q)
      S_TX_IDLE: begin
        if (bus.Start) begin
          xfer_d.addr      = bus.Start_address;
          xfer_d.remaining = bus.Word_count;
          state_d          = (bus.Word_count == '0) ? S_TX_DONE : S_TX_ISSUE_READ;
        end
      end

      S_TX_ISSUE_READ: begin
        sram_addr_d = xfer_q.addr;
        lat_d       = '0;
        state_d     = S_TX_WAIT_DATA;
      end

      // The address register adds one clock before the SRAM sees the new
      // address, so the wait counts 0..latency inclusive.
      S_TX_WAIT_DATA: begin
        if (lat_q == LAT_LAST) begin
          word_d  = bus.SRAM_read_data;
          state_d = S_TX_SEND_HIGH;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_TX_SEND_HIGH: begin
        tx_start = 1'b1;
        tx_data  = word_q[15:8];
        state_d  = S_TX_WAIT_HIGH;
      end

      S_TX_WAIT_HIGH: begin
        if (!tx_busy) state_d = bus.Abort ? S_TX_DONE : S_TX_SEND_LOW;
      end

      S_TX_SEND_LOW: begin
        tx_start = 1'b1;
        state_d  = S_TX_WAIT_LOW;
      end

      S_TX_WAIT_LOW: begin
        if (!tx_busy) begin
          xfer_d.addr      = next_word_addr(xfer_q.addr);
          xfer_d.remaining = xfer_q.remaining - SRAM_ADDR_W'(1);
          state_d          = (xfer_d.remaining == '0 || bus.Abort) ? S_TX_DONE : S_TX_ISSUE_READ;
        end
      end

      S_TX_DONE: state_d = S_TX_IDLE;

      default: state_d = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_TX_IDLE;
      xfer_q      <= '0;
      sram_addr_q <= '0;
      word_q      <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      sram_addr_q <= sram_addr_d;
      word_q      <= word_d;
      lat_q       <= lat_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .UART_TX_O  (tx_line)
  );

  assign bus.SRAM_address = sram_addr_q;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.UART_TX_O    = tx_line;
  assign bus.Busy         = (state_q != S_TX_IDLE) && (state_q != S_TX_DONE);
  assign bus.Done         = (state_q == S_TX_DONE);

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Directed bench: SRAM model, byte-list model of the expected UART stream,
// and a line monitor that checks every clock of every frame against it.
module tb_uart_sram_tx_interface;

  localparam int CLKS       = 434;
  localparam int LAT        = 2;
  localparam int FRAME_CLKS = 10 * CLKS;

  logic CLOCK_50_I;
  logic resetn;

  uart_sram_tx_interface_if bus ();

  uart_sram_tx_interface #(
    .CLKS_PER_BIT      (CLKS),
    .SRAM_READ_LATENCY (LAT)
  ) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .bus        (bus)
  );

  initial CLOCK_50_I = 1'b0;
  always #10 CLOCK_50_I = ~CLOCK_50_I;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // SRAM: address seen in cycle A gives data during cycle A+LAT.
  logic [15:0] mem [0:262143];
  logic [15:0] rd_p1;
  always @(posedge CLOCK_50_I) begin
    rd_p1              <= mem[bus.SRAM_address];
    bus.SRAM_read_data <= rd_p1;
  end

  int cyc = 0;
  always @(posedge CLOCK_50_I) cyc++;

  // Expected byte stream and observations.
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];
  int          frame_start_q [$];
  int          frame_end_q [$];
  logic [17:0] addr_seq [$];
  logic [17:0] last_addr;
  int frames_started, done_cnt, busy_cnt, low_cnt;
  int both_bad = 0;
  int we_bad   = 0;

  always @(negedge CLOCK_50_I) begin
    if (bus.Done === 1'b1) done_cnt++;
    if (bus.Busy === 1'b1) busy_cnt++;
    if (bus.Busy === 1'b1 && bus.Done === 1'b1) both_bad++;
    if (bus.SRAM_we_n !== 1'b1) we_bad++;
    if (bus.UART_TX_O !== 1'b1) low_cnt++;
    if (bus.Busy === 1'b1 && bus.SRAM_address !== last_addr) begin
      addr_seq.push_back(bus.SRAM_address);
      last_addr = bus.SRAM_address;
    end
  end

  always begin : uart_monitor
    logic [9:0] frame;
    logic [9:0] sh;
    logic [7:0] got;
    logic [7:0] exp_byte;
    int         bad, first, bi;
    bit         have, cut;
    @(negedge CLOCK_50_I);
    if (resetn === 1'b1 && bus.UART_TX_O === 1'b0) begin
      have = (exp_q.size() != 0);
      if (have) exp_byte = exp_q.pop_front();
      else      exp_byte = 8'h00;
      frame = {1'b1, exp_byte, 1'b0};
      frames_started++;
      first = cyc;
      bad   = 0;
      cut   = 1'b0;
      got   = 8'h00;
      for (int c = 0; c < FRAME_CLKS; c++) begin
        if (c != 0) @(negedge CLOCK_50_I);
        if (resetn !== 1'b1) begin
          cut = 1'b1;
          break;
        end
        bi = c / CLKS;
        sh = frame >> bi;
        if (bus.UART_TX_O !== sh[0]) bad++;
        if ((c % CLKS) == CLKS / 2 && bi >= 1 && bi <= 8) got = {bus.UART_TX_O, got[7:1]};
      end
      if (!cut) begin
        rx_q.push_back(got);
        frame_start_q.push_back(first);
        frame_end_q.push_back(cyc);
        check(have && bad == 0, "uart_frame", {24'd0, bad, got}, {56'd0, exp_byte});
      end
    end
  end

  task automatic clear_stats();
    exp_q.delete();
    rx_q.delete();
    frame_start_q.delete();
    frame_end_q.delete();
    addr_seq.delete();
    last_addr      = bus.SRAM_address;
    frames_started = 0;
    done_cnt       = 0;
    busy_cnt       = 0;
    low_cnt        = 0;
  endtask

  // Words go out high byte first; an abort during word k's high byte
  // stops the stream right after that byte.
  task automatic load_model(input logic [17:0] addr, input int cnt, input int abort_word);
    int          nb;
    logic [17:0] a;
    logic [15:0] w;
    nb = 2 * cnt;
    if (abort_word >= 0 && 2 * abort_word + 1 < nb) nb = 2 * abort_word + 1;
    for (int k = 0; k < nb; k++) begin
      a = addr + 18'(k / 2);
      w = mem[a];
      exp_q.push_back((k % 2 == 0) ? w[15:8] : w[7:0]);
    end
  endtask

  task automatic pulse_start(input logic [17:0] addr, input logic [17:0] cnt);
    @(negedge CLOCK_50_I);
    bus.Start_address = addr;
    bus.Word_count    = cnt;
    bus.Start         = 1'b1;
    @(negedge CLOCK_50_I);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge CLOCK_50_I);
    check(done_cnt != 0, {name, "_done_timeout"}, 64'(done_cnt), 64'd1);
    repeat (20) @(negedge CLOCK_50_I);
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    for (int i = 0; i < budget && frames_started < n; i++) @(negedge CLOCK_50_I);
    check(frames_started >= n, {name, "_frame_timeout"}, 64'(frames_started), 64'(n));
  endtask

  task automatic check_common(input string name, input int lit_n, input logic [63:0] lit, input int nwords);
    logic [63:0] packed_rx;
    int lo, hi, gap, lim, worst_over;
    packed_rx = '0;
    foreach (rx_q[i]) packed_rx = {packed_rx[55:0], rx_q[i]};
    check(rx_q.size() == lit_n && packed_rx == lit, {name, "_bytes"}, packed_rx, lit);
    check(exp_q.size() == 0, {name, "_model_drained"}, 64'(exp_q.size()), 64'd0);
    check(done_cnt == 1, {name, "_done_once"}, 64'(done_cnt), 64'd1);
    lo = lit_n * FRAME_CLKS;
    hi = lo + nwords * 10 + 4;
    check(busy_cnt >= lo && busy_cnt <= hi, {name, "_busy_span"}, 64'(busy_cnt), 64'(lo));
    worst_over = 0;
    for (int i = 1; i < frame_start_q.size(); i++) begin
      gap = frame_start_q[i] - frame_end_q[i-1] - 1;
      lim = (i % 2 == 1) ? 3 : LAT + 4;
      if (gap - lim > worst_over) worst_over = gap - lim;
    end
    check(worst_over == 0, {name, "_gaps"}, 64'(worst_over), 64'd0);
    check(bus.UART_TX_O === 1'b1 && bus.Busy === 1'b0, {name, "_idle_after"},
          {62'd0, bus.UART_TX_O, bus.Busy}, 64'd2);
  endtask

  initial begin
    logic [17:0] a;
    for (int i = 0; i < 262144; i++) begin
      a      = 18'(i);
      mem[i] = {a[11:4], a[7:0]};
    end
    mem[18'h00010] = 16'hA55A;
    mem[18'h3FFFF] = 16'h1234;
    mem[18'h00000] = 16'hBEEF;

    resetn            = 1'b0;
    bus.Start         = 1'b0;
    bus.Abort         = 1'b0;
    bus.Start_address = '0;
    bus.Word_count    = '0;
    rd_p1             = '0;
    bus.SRAM_read_data = '0;
    repeat (3) @(negedge CLOCK_50_I);
    check(bus.UART_TX_O === 1'b1, "rst_line", 64'(bus.UART_TX_O), 64'd1);
    check(bus.Busy === 1'b0, "rst_busy", 64'(bus.Busy), 64'd0);
    check(bus.Done === 1'b0, "rst_done", 64'(bus.Done), 64'd0);
    check(bus.SRAM_address === 18'h0, "rst_addr", 64'(bus.SRAM_address), 64'd0);
    check(bus.SRAM_we_n === 1'b1, "rst_we_n", 64'(bus.SRAM_we_n), 64'd1);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50_I);

    // One word, A55A at 0x10.
    clear_stats();
    load_model(18'h00010, 1, -1);
    pulse_start(18'h00010, 18'd1);
    wait_done("one_word", 12000);
    check_common("one_word", 2, 64'hA55A, 1);
    check(bus.SRAM_address === 18'h00010, "one_word_addr_hold", 64'(bus.SRAM_address), 64'h10);

    // Zero words: Done only, nothing on the line, no read.
    clear_stats();
    pulse_start(18'h00155, 18'd0);
    repeat (2) @(negedge CLOCK_50_I);
    check(done_cnt == 1, "zero_done_fast", 64'(done_cnt), 64'd1);
    repeat (20) @(negedge CLOCK_50_I);
    check(done_cnt == 1 && busy_cnt == 0, "zero_no_busy", 64'(busy_cnt), 64'd0);
    check(low_cnt == 0 && frames_started == 0, "zero_line_high", 64'(low_cnt), 64'd0);
    check(bus.SRAM_address === 18'h00010, "zero_addr_unchanged", 64'(bus.SRAM_address), 64'h10);

    // Address wrap from the top of SRAM.
    clear_stats();
    load_model(18'h3FFFF, 2, -1);
    pulse_start(18'h3FFFF, 18'd2);
    wait_done("wrap", 22000);
    check_common("wrap", 4, 64'h1234BEEF, 2);
    check(addr_seq.size() == 2 && addr_seq[0] == 18'h3FFFF && addr_seq[1] == 18'h00000,
          "wrap_addr_seq", 64'(addr_seq.size()), 64'd2);

    // Abort during the second word's high byte: three bytes.
    clear_stats();
    load_model(18'h00100, 4, 1);
    pulse_start(18'h00100, 18'd4);
    wait_frames("abort", 3, 12000);
    repeat (1000) @(negedge CLOCK_50_I);
    bus.Abort = 1'b1;
    wait_done("abort", 8000);
    bus.Abort = 1'b0;
    check_common("abort", 3, 64'h100010, 2);

    // A second Start while busy is ignored.
    clear_stats();
    load_model(18'h00200, 3, -1);
    pulse_start(18'h00200, 18'd3);
    repeat (3000) @(negedge CLOCK_50_I);
    pulse_start(18'h00010, 18'd1);
    wait_done("restart", 30000);
    check_common("restart", 6, 64'h200020012002, 3);

    // Start and Abort together: the first byte still goes out.
    clear_stats();
    load_model(18'h00300, 2, 0);
    bus.Abort = 1'b1;
    pulse_start(18'h00300, 18'd2);
    wait_done("start_abort", 6000);
    bus.Abort = 1'b0;
    check_common("start_abort", 1, 64'h30, 1);

    // Asynchronous reset in the middle of a data bit.
    clear_stats();
    load_model(18'h00010, 1, -1);
    pulse_start(18'h00010, 18'd1);
    wait_frames("midrst", 1, 100);
    repeat (3 * CLKS + CLKS / 2) @(negedge CLOCK_50_I);
    #3 resetn = 1'b0;
    #2;
    check(bus.UART_TX_O === 1'b1, "midrst_line", 64'(bus.UART_TX_O), 64'd1);
    check(bus.Busy === 1'b0 && bus.Done === 1'b0, "midrst_busy_done",
          {62'd0, bus.Busy, bus.Done}, 64'd0);
    check(bus.SRAM_address === 18'h0, "midrst_addr", 64'(bus.SRAM_address), 64'd0);
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50_I);
    clear_stats();
    load_model(18'h00000, 1, -1);
    pulse_start(18'h00000, 18'd1);
    wait_done("postrst", 12000);
    check_common("postrst", 2, 64'hBEEF, 1);

    check(we_bad == 0, "we_n_const", 64'(we_bad), 64'd0);
    check(both_bad == 0, "busy_done_exclusive", 64'(both_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
